latch_bank_scan_reader: RTL and testbench
=========================================

Name: latch_bank_scan_reader

Overview:
- Reader for a bank of transparent latches of the latsnq/latrnq family.
- Freezes the bank by driving its latch enable low, captures the held word, then shifts it out serially over a valid/ready handshake.
- Sits between a latch-based register bank (the writer side) and a bit-serial scan/debug consumer.
- Releases the bank back to transparent once the word is fully drained.

Parameters:
- WIDTH, 8, number of latch bits read per transaction (>=1).
- LSB_FIRST, 1, 1: bit 0 shifted out first; 0: bit WIDTH-1 first.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous active-low reset.
- REQ  input  1  read request, level-sampled in IDLE.
- ACK  output  1  one-cycle pulse when the final bit has been accepted.
- LE  output  1  latch-bank enable (1 = transparent, 0 = hold).
- D  input  WIDTH  latch-bank Q outputs.
- SO  output  1  serial data.
- SO_VALID  output  1  SO holds a valid bit.
- SO_READY  input  1  consumer accepts SO this cycle.
- SO_LAST  output  1  current bit is the final bit of the word.
- BUSY  output  1  high in every state except IDLE.

Behaviour:
- Reset (RN=0, asynchronous, any state):
  - State goes to IDLE; shift register and counter clear to 0.
  - Outputs: LE=1, ACK=0, SO=0, SO_VALID=0, SO_LAST=0, BUSY=0.
- Reset release is synchronous to CLK; the first active edge after RN rises evaluates IDLE.
- FSM states: IDLE, FREEZE, CAPTURE, SHIFT, DONE.
- IDLE:
  - LE=1.
  - REQ=1 at an edge: go to FREEZE and drive LE=0 from that edge.
- FREEZE:
  - One settle cycle with LE=0 so the latches are opaque before sampling.
  - Always goes to CAPTURE.
- CAPTURE:
  - At the edge, load D into the WIDTH-bit shift register and load the counter with WIDTH-1.
  - Go to SHIFT.
  - Total latency from the REQ-sampling edge to the first SO_VALID is 2 cycles.
- SHIFT:
  - SO_VALID=1.
  - SO = sreg[0] when LSB_FIRST=1, else sreg[WIDTH-1].
  - SO_LAST = (counter==0).
  - Handshake on SO_VALID & SO_READY at an edge:
    - If not last: shift by one toward the output end (zero fill) and decrement the counter.
    - If last: go to DONE.
  - SO_READY=0 stalls indefinitely; SO and SO_LAST stay stable while SO_VALID=1 and SO_READY=0.
  - SO_READY while SO_VALID=0 is ignored.
- DONE:
  - One cycle with ACK=1, SO_VALID=0, LE=1 (bank transparent again).
  - Always returns to IDLE.
  - A REQ still high in IDLE starts a new transaction, so back-to-back requests cost 1 idle cycle.
- LE is a registered output and never glitches; LE=0 exactly in FREEZE, CAPTURE and SHIFT.
- REQ is ignored in every state except IDLE; no queuing.
- Counter width is max(1, clog2(WIDTH)).
- WIDTH=1: SO_LAST=1 on the first and only bit.
- D is sampled only at the CAPTURE edge; changes on D after that have no effect on the word being shifted.
- Reset mid-transaction:
  - The word is discarded and LE returns to 1 immediately (asynchronously).
  - No ACK is issued.
  - The consumer sees SO_VALID drop without SO_LAST.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, FREEZE, CAPTURE, SHIFT, DONE), 3-bit encoding;
  - the LE polarity constants (LE_TRANSPARENT=1, LE_HOLD=0).
- One sub-module, latch_bank_piso:
  - WIDTH-bit parallel-load, direction-parameterised shift register with a down-counter and last flag;
  - controlled by load/shift strobes from the FSM.
- The top level holds the FSM and the output registers.

Test Plan:
- Basic read, WIDTH=8, LSB_FIRST=1, D=8'hA5, SO_READY=1: LE falls 1 cycle after REQ; SO sequence 1,0,1,0,0,1,0,1; SO_LAST only on the 8th bit; ACK pulses the cycle after; LE=1 in DONE.
- Back-pressure, D=8'h3C, LSB_FIRST=0, SO_READY toggles 1,0,0,1,...: SO and SO_LAST held through stalls; bits read 0,0,1,1,1,1,0,0; exactly 8 handshakes before ACK.
- D changes to 8'hFF after the CAPTURE edge, while LE=0: the shifted word is still the captured 8'h5A, not 8'hFF.
- RN pulsed low during the 4th bit: LE=1, SO_VALID=0, BUSY=0 immediately; no ACK; the next REQ reads the current D correctly.
- REQ held high continuously, D=8'h01 then 8'h80: two complete transactions separated by exactly 1 IDLE cycle; a REQ level during SHIFT causes no disturbance.
- WIDTH=1, D=1'b1: a single beat with SO=1 and SO_LAST=1, then ACK; FREEZE-to-DONE sequence intact.

Source files
------------

// File: rtl/latch_bank_scan_reader_pkg.sv
// Shared types for the latch bank scan reader.
// State encoding and latch-enable polarity.
package latch_bank_scan_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FREEZE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic LE_TRANSPARENT = 1'b1;
    localparam logic LE_HOLD        = 1'b0;

    function automatic logic bank_held(input state_t s);
        return (s == ST_FREEZE) || (s == ST_CAPTURE) || (s == ST_SHIFT);
    endfunction

endpackage

// File: rtl/latch_bank_scan_reader_piso.sv
// Parallel-load shift register with beat down-counter.
// Shifts toward the output end selected by LSB_FIRST.
module latch_bank_scan_reader_piso #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned CW        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             so,
    output logic             last
);

    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= d;
            cnt  <= CW'(WIDTH - 1);
        end else if (shift) begin
            sreg <= LSB_FIRST ? (sreg >> 1) : (sreg << 1);
            cnt  <= cnt - CW'(1);
        end
    end

    assign so   = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
    assign last = (cnt == '0);

endmodule

// File: rtl/latch_bank_scan_reader.sv
// Freezes a latch bank, captures its word and shifts it out
// serially over a valid/ready handshake.
module latch_bank_scan_reader
    import latch_bank_scan_reader_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             REQ,
    output logic             ACK,
    output logic             LE,
    input  logic [WIDTH-1:0] D,
    output logic             SO,
    output logic             SO_VALID,
    input  logic             SO_READY,
    output logic             SO_LAST,
    output logic             BUSY
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t state, state_nxt;
    logic   load, shift;
    logic   so_raw, last_raw;
    logic   le_q, ack_q;

    latch_bank_scan_reader_piso #(
        .WIDTH    (WIDTH),
        .LSB_FIRST(LSB_FIRST),
        .CW       (CW)
    ) u_piso (
        .clk  (CLK),
        .rst_n(RN),
        .load (load),
        .shift(shift),
        .d    (D),
        .so   (so_raw),
        .last (last_raw)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        unique case (state)
            ST_IDLE:    if (REQ) state_nxt = ST_FREEZE;
            ST_FREEZE:  state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                load      = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (SO_READY) begin
                    if (last_raw) state_nxt = ST_DONE;
                    else          shift     = 1'b1;
                end
            end
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // LE and ACK are registered from the next state so they never glitch
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= ST_IDLE;
            le_q  <= LE_TRANSPARENT;
            ack_q <= 1'b0;
        end else begin
            state <= state_nxt;
            le_q  <= bank_held(state_nxt) ? LE_HOLD : LE_TRANSPARENT;
            ack_q <= (state_nxt == ST_DONE);
        end
    end

    assign LE       = le_q;
    assign ACK      = ack_q;
    assign SO_VALID = (state == ST_SHIFT);
    assign SO       = so_raw & SO_VALID;
    assign SO_LAST  = last_raw & SO_VALID;
    assign BUSY     = (state != ST_IDLE);

endmodule

// File: tb/tb_latch_bank_scan_reader.sv
// Self-checking bench for latch_bank_scan_reader.
// Three instances: 8-bit LSB-first, 8-bit MSB-first, 1-bit.
module tb_latch_bank_scan_reader;

    logic       clk = 1'b0;
    logic       rn;
    logic       req [3];
    logic       rdy [3];
    logic [7:0] d   [3];
    logic       ack [3];
    logic       le  [3];
    logic       so  [3];
    logic       sov [3];
    logic       sol [3];
    logic       busy[3];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    latch_bank_scan_reader #(.WIDTH(8), .LSB_FIRST(1'b1)) u0 (
        .CLK(clk), .RN(rn), .REQ(req[0]), .ACK(ack[0]), .LE(le[0]),
        .D(d[0]), .SO(so[0]), .SO_VALID(sov[0]), .SO_READY(rdy[0]),
        .SO_LAST(sol[0]), .BUSY(busy[0]));

    latch_bank_scan_reader #(.WIDTH(8), .LSB_FIRST(1'b0)) u1 (
        .CLK(clk), .RN(rn), .REQ(req[1]), .ACK(ack[1]), .LE(le[1]),
        .D(d[1]), .SO(so[1]), .SO_VALID(sov[1]), .SO_READY(rdy[1]),
        .SO_LAST(sol[1]), .BUSY(busy[1]));

    latch_bank_scan_reader #(.WIDTH(1), .LSB_FIRST(1'b1)) u2 (
        .CLK(clk), .RN(rn), .REQ(req[2]), .ACK(ack[2]), .LE(le[2]),
        .D(d[2][0]), .SO(so[2]), .SO_VALID(sov[2]), .SO_READY(rdy[2]),
        .SO_LAST(sol[2]), .BUSY(busy[2]));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // bit i of the serial stream, from the word and the shift order
    function automatic logic exp_bit(input logic [7:0] w, input int width,
                                     input bit lsb, input int i);
        return lsb ? w[i] : w[width-1-i];
    endfunction

    task automatic chk_idle(input int u, input string tag);
        chk({tag, "_le"},   32'(le[u]),   1);
        chk({tag, "_ack"},  32'(ack[u]),  0);
        chk({tag, "_so"},   32'(so[u]),   0);
        chk({tag, "_vld"},  32'(sov[u]),  0);
        chk({tag, "_last"}, 32'(sol[u]),  0);
        chk({tag, "_busy"}, 32'(busy[u]), 0);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random
    task automatic run_txn(input int u, input logic [7:0] w,
                           input int width, input bit lsb, input int mode,
                           input bit hold_req, input bit change_d);
        int beats;
        int cyc;
        d[u]   = w;
        req[u] = 1'b1;
        rdy[u] = 1'b0;
        @(posedge clk); #1;
        chk("freeze_le",   32'(le[u]),   0);
        chk("freeze_busy", 32'(busy[u]), 1);
        chk("freeze_vld",  32'(sov[u]),  0);
        if (!hold_req) req[u] = 1'b0;
        @(posedge clk); #1;
        chk("capture_le",  32'(le[u]),  0);
        chk("capture_vld", 32'(sov[u]), 0);
        @(posedge clk); #1;
        if (change_d) d[u] = 8'hFF;
        beats = 0;
        cyc   = 0;
        while (beats < width && cyc < 200) begin
            case (mode)
                0:       rdy[u] = 1'b1;
                1:       rdy[u] = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy[u] = 1'($urandom_range(0, 1));
            endcase
            chk("shift_vld", 32'(sov[u]), 1);
            chk("shift_le",  32'(le[u]),  0);
            chk("shift_ack", 32'(ack[u]), 0);
            chk("so",   32'(so[u]),  32'(exp_bit(w, width, lsb, beats)));
            chk("last", 32'(sol[u]), 32'(beats == width - 1));
            @(posedge clk); #1;
            if (rdy[u]) beats++;
            cyc++;
        end
        rdy[u] = 1'b0;
        if (beats < width) chk("beat_timeout", beats, width);
        chk("done_ack",  32'(ack[u]),  1);
        chk("done_vld",  32'(sov[u]),  0);
        chk("done_le",   32'(le[u]),   1);
        chk("done_busy", 32'(busy[u]), 1);
        @(posedge clk); #1;
        chk("idle_ack",  32'(ack[u]),  0);
        chk("idle_busy", 32'(busy[u]), 0);
        chk("idle_le",   32'(le[u]),   1);
        chk("idle_vld",  32'(sov[u]),  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0;
            rdy[i] = 1'b0;
            d[i]   = 8'h00;
        end
        req[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk_idle(i, "reset");
        req[0] = 1'b0;
        @(negedge clk);
        rn = 1'b1;
        @(posedge clk); #1;

        run_txn(0, 8'hA5, 8, 1'b1, 0, 1'b0, 1'b0);
        run_txn(1, 8'h3C, 8, 1'b0, 1, 1'b0, 1'b0);
        run_txn(0, 8'h5A, 8, 1'b1, 0, 1'b0, 1'b1);

        // reset during the 4th bit
        d[0]   = 8'hC3;
        req[0] = 1'b1;
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rdy[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst4_so",   32'(so[0]),  32'(exp_bit(8'hC3, 8, 1'b1, 3)));
        chk("rst4_vld",  32'(sov[0]), 1);
        rdy[0] = 1'b0;
        rn     = 1'b0;
        #1;
        chk_idle(0, "midrst");
        @(negedge clk);
        rn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ack",  32'(ack[0]),  0);
        chk("post_rst_busy", 32'(busy[0]), 0);
        d[0] = 8'h96;
        run_txn(0, 8'h96, 8, 1'b1, 2, 1'b0, 1'b0);

        // REQ held high: back-to-back with one idle cycle
        run_txn(0, 8'h01, 8, 1'b1, 0, 1'b1, 1'b0);
        run_txn(0, 8'h80, 8, 1'b1, 2, 1'b1, 1'b0);
        req[0] = 1'b0;
        @(posedge clk); #1;
        chk("hold_end_busy", 32'(busy[0]), 0);

        run_txn(2, 8'h01, 1, 1'b1, 0, 1'b0, 1'b0);
        run_txn(2, 8'h00, 1, 1'b1, 2, 1'b0, 1'b1);

        for (int n = 0; n < 8; n++) begin
            logic [7:0] w;
            int         u;
            w = 8'($urandom);
            u = n % 2;
            run_txn(u, w, 8, (u == 0), 2, 1'b0, 1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 4; n++)
            run_txn(2, 8'($urandom_range(0, 1)), 1, 1'b1, 2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
